traffic_lamp_monitor: RTL and testbench

Passive checker on the lamp side of the two-approach intersection controller. It samples the six lamp outputs (Ra/Ya/Ga, Rb/Yb/Gb) and the two traffic sensors (Ta, Tb), and decodes a phase for each approach. It flags malformed lamp patterns, conflicting right-of-way, illegal phase sequences and yellow-dwell violations, and counts completed signal cycles. It drives nothing back into the controller and sits beside it in the top level and in the bench.

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/lamp_phase_tracker.sv | 88 ++++++++
 rtl/traffic_lamp_monitor.sv | 148 ++++++++++++++
 tb/tb_traffic_lamp_monitor.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_pkg: phase encoding, error-bit indices and lamp decode helper    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_UNK = 2'b00,
        PH_GRN = 2'b01,
        PH_YEL = 2'b10,
        PH_RED = 2'b11
    } phase_e;

    localparam int ERR_W        = 5;
    localparam int ERR_LAMP_A   = 0;
    localparam int ERR_LAMP_B   = 1;
    localparam int ERR_CONFLICT = 2;
    localparam int ERR_SEQ      = 3;
    localparam int ERR_STARVE   = 4;

    typedef struct packed {
        logic ra;
        logic ya;
        logic ga;
        logic rb;
        logic yb;
        logic gb;
        logic ta;
        logic tb;
    } lamp_sample_t;

    // Any pattern other than exactly one lamp lit decodes as UNK.
    function automatic phase_e decode_lamps(input logic r, input logic y, input logic g);
        case ({r, y, g})
            3'b100:  return PH_RED;
            3'b010:  return PH_YEL;
            3'b001:  return PH_GRN;
            default: return PH_UNK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lamp_phase_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lamp_phase_tracker: per-approach decode, phase tracker, yellow dwell     |
// | and lamp/sequence error pulses                                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lamp_phase_tracker
    import traffic_pkg::*;
#(
    parameter int YEL_MIN = 1,
    parameter int YEL_MAX = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   lamp_r,
    input  logic   lamp_y,
    input  logic   lamp_g,
    output phase_e phase,
    output phase_e dec_phase,
    output logic   lamp_err,
    output logic   seq_err,
    output logic   red_to_grn
);

    localparam logic [7:0] YEL_MIN_C = 8'(YEL_MIN);
    localparam logic [7:0] YEL_MAX_C = 8'(YEL_MAX);

    phase_e     phase_q, phase_d;
    logic [7:0] dwell_q, dwell_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PH_UNK;
            dwell_q <= '0;
        end else begin
            phase_q <= phase_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        phase_d    = phase_q;
        dwell_d    = dwell_q;
        lamp_err   = 1'b0;
        seq_err    = 1'b0;
        red_to_grn = 1'b0;
        dec_phase  = decode_lamps(lamp_r, lamp_y, lamp_g);
        if (en) begin
            if (dec_phase == PH_UNK) begin
                lamp_err = 1'b1;
                phase_d  = PH_UNK;
                dwell_d  = '0;
            end else begin
                phase_d = dec_phase;
                // From UNK any valid phase is a silent resync.
                case (phase_q)
                    PH_GRN: begin
                        if (dec_phase == PH_RED) seq_err = 1'b1;
                    end
                    PH_YEL: begin
                        if (dec_phase == PH_GRN) seq_err = 1'b1;
                        if (dec_phase == PH_RED && dwell_q < YEL_MIN_C) seq_err = 1'b1;
                    end
                    PH_RED: begin
                        if (dec_phase == PH_YEL) seq_err = 1'b1;
                        if (dec_phase == PH_GRN) red_to_grn = 1'b1;
                    end
                    default: ;
                endcase
                if (dec_phase == PH_YEL) begin
                    if (phase_q == PH_YEL) begin
                        dwell_d = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
                    end else begin
                        dwell_d = 8'd1;
                    end
                    if (dwell_d > YEL_MAX_C) seq_err = 1'b1;
                end else begin
                    dwell_d = '0;
                end
            end
        end
    end

    assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/traffic_lamp_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_lamp_monitor: passive lamp-side checker for a two-approach       |
// | intersection. Optional starvation watchdog: TRAFFIC_LAMP_MON_STARVE_EN   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int YEL_MIN  = 1,
    parameter int YEL_MAX  = 1,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             Ra,
    input  logic             Ya,
    input  logic             Ga,
    input  logic             Rb,
    input  logic             Yb,
    input  logic             Gb,
    input  logic             Ta,
    input  logic             Tb,
    output logic [1:0]       phase_a,
    output logic [1:0]       phase_b,
    output logic [ERR_W-1:0] err,
    output logic             err_any,
    output logic [CNT_W-1:0] cycle_count
);

    lamp_sample_t     samp_q, samp_d;
    logic             samp_vld_q, samp_vld_d;
    logic [ERR_W-1:0] err_q, err_d, err_new;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    phase_e phase_a_w, phase_b_w, dec_a, dec_b;
    logic   lamp_err_a, lamp_err_b, seq_err_a, seq_err_b;
    logic   r2g_a, unused_r2g_b;
    logic   starve;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_q        <= '0;
            samp_vld_q    <= 1'b0;
            err_q         <= '0;
            cycle_count_q <= '0;
        end else begin
            samp_q        <= samp_d;
            samp_vld_q    <= samp_vld_d;
            err_q         <= err_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    lamp_phase_tracker #(.YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX)) u_trk_a (
        .clk       (clk),
        .reset     (reset),
        .en        (samp_vld_q),
        .lamp_r    (samp_q.ra),
        .lamp_y    (samp_q.ya),
        .lamp_g    (samp_q.ga),
        .phase     (phase_a_w),
        .dec_phase (dec_a),
        .lamp_err  (lamp_err_a),
        .seq_err   (seq_err_a),
        .red_to_grn(r2g_a)
    );

    lamp_phase_tracker #(.YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX)) u_trk_b (
        .clk       (clk),
        .reset     (reset),
        .en        (samp_vld_q),
        .lamp_r    (samp_q.rb),
        .lamp_y    (samp_q.yb),
        .lamp_g    (samp_q.gb),
        .phase     (phase_b_w),
        .dec_phase (dec_b),
        .lamp_err  (lamp_err_b),
        .seq_err   (seq_err_b),
        .red_to_grn(unused_r2g_b)
    );

`ifdef TRAFFIC_LAMP_MON_STARVE_EN
    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_a_q, wait_a_d, wait_b_q, wait_b_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_a_q <= '0;
            wait_b_q <= '0;
        end else begin
            wait_a_q <= wait_a_d;
            wait_b_q <= wait_b_d;
        end
    end

    // Each counter holds at the limit so the flag keeps re-asserting while starved.
    always_comb begin
        wait_a_d = '0;
        wait_b_d = '0;
        if (phase_a_w == PH_GRN && samp_q.tb) begin
            wait_a_d = (wait_a_q == WAIT_LIM) ? wait_a_q : wait_a_q + WAIT_W'(1);
        end
        if (phase_b_w == PH_GRN && samp_q.ta) begin
            wait_b_d = (wait_b_q == WAIT_LIM) ? wait_b_q : wait_b_q + WAIT_W'(1);
        end
        starve = (wait_a_d == WAIT_LIM) || (wait_b_d == WAIT_LIM);
    end
`else
    logic unused_wd_inputs;
    assign unused_wd_inputs = ^{samp_q.ta, samp_q.tb, 1'(MAX_WAIT)};
    assign starve           = 1'b0;
`endif

    always_comb begin
        samp_d     = '{ra: Ra, ya: Ya, ga: Ga, rb: Rb, yb: Yb, gb: Gb, ta: Ta, tb: Tb};
        samp_vld_d = 1'b1;

        err_new               = '0;
        err_new[ERR_LAMP_A]   = lamp_err_a;
        err_new[ERR_LAMP_B]   = lamp_err_b;
        err_new[ERR_CONFLICT] = samp_vld_q && (dec_a != PH_UNK) && (dec_b != PH_UNK)
                                && (dec_a != PH_RED) && (dec_b != PH_RED);
        err_new[ERR_SEQ]      = seq_err_a | seq_err_b;
        err_new[ERR_STARVE]   = starve;
        // A new error in the clear cycle survives; a count increment does not.
        err_d = (clr ? '0 : err_q) | err_new;

        cycle_count_d = cycle_count_q;
        if (clr) begin
            cycle_count_d = '0;
        end else if (r2g_a && cycle_count_q != {CNT_W{1'b1}}) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
    end

    assign phase_a     = phase_a_w;
    assign phase_b     = phase_b_w;
    assign err         = err_q;
    assign err_any     = |err_q;
    assign cycle_count = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_lamp_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_traffic_lamp_monitor: directed plus randomized stimulus against a     |
// | behavioural reference model. Honours TRAFFIC_LAMP_MON_STARVE_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_traffic_lamp_monitor;

    localparam int YEL_MIN  = 2;
    localparam int YEL_MAX  = 3;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    localparam logic [2:0] P_G = 3'b001;
    localparam logic [2:0] P_Y = 3'b010;
    localparam logic [2:0] P_R = 3'b100;

`ifdef TRAFFIC_LAMP_MON_STARVE_EN
    localparam logic STARVE_EXP = 1'b1;
`else
    localparam logic STARVE_EXP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, clr;
    logic             Ra, Ya, Ga, Rb, Yb, Gb, Ta, Tb;
    logic [1:0]       phase_a, phase_b;
    logic [4:0]       err;
    logic             err_any;
    logic [CNT_W-1:0] cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phases use the output code (0 UNK, 1 GRN, 2 YEL, 3 RED).
    int         m_ph_a, m_ph_b, m_dw_a, m_dw_b, m_cnt, m_wait_a, m_wait_b;
    logic [4:0] m_err;
    bit         m_vld;
    logic [7:0] m_samp;

    traffic_lamp_monitor #(
        .YEL_MIN (YEL_MIN),
        .YEL_MAX (YEL_MAX),
        .MAX_WAIT(MAX_WAIT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .Ra         (Ra),
        .Ya         (Ya),
        .Ga         (Ga),
        .Rb         (Rb),
        .Yb         (Yb),
        .Gb         (Gb),
        .Ta         (Ta),
        .Tb         (Tb),
        .phase_a    (phase_a),
        .phase_b    (phase_b),
        .err        (err),
        .err_any    (err_any),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lamp_phase(input logic r, input logic y, input logic g);
        if (int'(r) + int'(y) + int'(g) != 1) return 0;
        if (g) return 1;
        if (y) return 2;
        return 3;
    endfunction

    // Green, yellow, red form a ring; staying put or stepping one place forward is legal.
    task automatic advance(input int old_ph, input int old_dw, input logic r, input logic y,
                           input logic g, output int new_ph, output int new_dw,
                           output bit lamp, output bit seq, output bit wrap);
        int p;
        p      = lamp_phase(r, y, g);
        new_ph = p;
        new_dw = 0;
        lamp   = 0;
        seq    = 0;
        wrap   = 0;
        if (p == 0) begin
            lamp = 1;
        end else begin
            if (old_ph != 0) begin
                if (!(p == old_ph || (p - 1) == (old_ph % 3))) seq = 1;
                if (old_ph == 2 && p == 3 && old_dw < YEL_MIN) seq = 1;
                if (old_ph == 3 && p == 1) wrap = 1;
            end
            if (p == 2) begin
                new_dw = (old_ph == 2) ? old_dw + 1 : 1;
                if (new_dw > YEL_MAX) seq = 1;
            end
        end
    endtask

    task automatic model_reset();
        m_ph_a = 0; m_ph_b = 0; m_dw_a = 0; m_dw_b = 0;
        m_cnt = 0; m_wait_a = 0; m_wait_b = 0;
        m_err = '0; m_vld = 0; m_samp = '0;
    endtask

    task automatic model_edge();
        logic [4:0] ne;
        int         na, nb, da, db;
        bit         la, lb, sa, sb, wa, wb;
        if (reset !== 1'b1) return;
        ne = '0;
        wa = 0;
`ifdef TRAFFIC_LAMP_MON_STARVE_EN
        m_wait_a = (m_ph_a == 1 && m_samp[0]) ? ((m_wait_a < MAX_WAIT) ? m_wait_a + 1 : MAX_WAIT) : 0;
        m_wait_b = (m_ph_b == 1 && m_samp[1]) ? ((m_wait_b < MAX_WAIT) ? m_wait_b + 1 : MAX_WAIT) : 0;
        if (m_wait_a == MAX_WAIT || m_wait_b == MAX_WAIT) ne[4] = 1'b1;
`endif
        if (m_vld) begin
            advance(m_ph_a, m_dw_a, m_samp[7], m_samp[6], m_samp[5], na, da, la, sa, wa);
            advance(m_ph_b, m_dw_b, m_samp[4], m_samp[3], m_samp[2], nb, db, lb, sb, wb);
            ne[0] = la;
            ne[1] = lb;
            ne[2] = (na != 0 && nb != 0 && na != 3 && nb != 3);
            ne[3] = sa | sb;
            m_ph_a = na; m_dw_a = da;
            m_ph_b = nb; m_dw_b = db;
        end
        m_err = (clr ? 5'd0 : m_err) | ne;
        if (clr) m_cnt = 0;
        else if (wa && m_cnt < CNT_MAX) m_cnt++;
        m_samp = {Ra, Ya, Ga, Rb, Yb, Gb, Ta, Tb};
        m_vld  = 1;
    endtask

    task automatic check_outputs();
        check_value("phase_a", phase_a, m_ph_a);
        check_value("phase_b", phase_b, m_ph_b);
        check_value("err", err, m_err);
        check_value("err_any", err_any, |m_err);
        check_value("cycle_count", cycle_count, m_cnt);
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic ta,
                         input logic tb, input logic c);
        {Ra, Ya, Ga} = a;
        {Rb, Yb, Gb} = b;
        Ta  = ta;
        Tb  = tb;
        clr = c;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic step(input logic [2:0] a, input logic [2:0] b, input int n);
        drive(a, b, 1'b0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic drive_random_lamps();
        drive(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Called just after an active edge; asserts reset asynchronously.
    task automatic pulse_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (cycles) begin
            drive_random_lamps();
            tick();
        end
        reset = 1'b1;
    endtask

    function automatic logic [2:0] pat(input int p);
        case (p)
            1:       return P_G;
            2:       return P_Y;
            default: return P_R;
        endcase
    endfunction

    initial begin
        logic [2:0] la [9];
        logic [2:0] lb [9];
        int         gph_a, gph_b;
        logic [2:0] pa, pb;

        reset = 1'b1;
        drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (3) begin
            drive_random_lamps();
            tick();
        end
        check_value("reset_err", err, 5'd0);
        reset = 1'b1;

        // Full legal cycle on A with B taking its turn while A is red.
        la = '{P_G, P_G, P_Y, P_Y, P_R, P_R, P_R, P_R, P_G};
        lb = '{P_R, P_R, P_R, P_R, P_G, P_Y, P_Y, P_R, P_R};
        for (int i = 0; i < 9; i++) step(la[i], lb[i], 1);
        step(P_G, P_R, 2);
        check_value("legal_err", err, 5'd0);
        check_value("legal_count", cycle_count, 1);

        step(P_R, P_G, 2);
        check_value("illegal_seq", err[3], 1'b1);
        step(P_R, P_G, 2);
        check_value("illegal_sticky", err[3], 1'b1);
        drive(P_R, P_G, 1'b0, 1'b0, 1'b1);
        tick();
        check_value("illegal_clr", err[3], 1'b0);

        step(P_R, P_Y, 2);
        step(P_R, P_R, 1);
        step(3'b011, P_R, 1);
        step(P_G, P_R, 1);
        check_value("invalid_lamp", err[0], 1'b1);
        check_value("invalid_unk", phase_a, 2'b00);
        step(P_G, P_R, 1);
        check_value("resync_phase", phase_a, 2'b01);
        check_value("resync_noseq", err[3], 1'b0);

        step(P_G, P_G, 1);
        drive(P_G, P_G, 1'b0, 1'b0, 1'b1);
        tick();
        check_value("conflict_vs_clr", err[2], 1'b1);
        check_value("conflict_any", err_any, 1'b1);
        step(P_G, P_R, 2);
        drive(P_G, P_R, 1'b0, 1'b0, 1'b1);
        tick();
        check_value("clr_all", err, 5'd0);

        drive(P_G, P_R, 1'b0, 1'b1, 1'b0);
        repeat (4) tick();
        step(P_G, P_R, 1);
        check_value("starve", err[4], STARVE_EXP);
        drive(P_G, P_R, 1'b0, 1'b0, 1'b1);
        tick();

        // Nine legal A cycles push the narrow counter past its ceiling.
        repeat (9) begin
            step(P_Y, P_R, 2);
            step(P_R, P_R, 1);
            step(P_G, P_R, 1);
        end
        step(P_G, P_R, 2);
        check_value("count_sat", cycle_count, CNT_MAX);
        check_value("sat_noerr", err, 5'd0);

        step(P_Y, P_R, 1);
        step(P_R, P_R, 2);
        check_value("dwell_short", err[3], 1'b1);
        drive(P_R, P_R, 1'b0, 1'b0, 1'b1);
        tick();
        step(P_G, P_R, 1);
        step(P_Y, P_R, 4);
        step(P_Y, P_R, 1);
        check_value("dwell_long", err[3], 1'b1);

        gph_a = 1;
        gph_b = 3;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset(int'($urandom_range(1, 3)));
            end
            if ($urandom_range(0, 99) < 8) gph_a = int'($urandom_range(1, 3));
            else if ($urandom_range(0, 99) < 30) gph_a = gph_a % 3 + 1;
            if ($urandom_range(0, 99) < 8) gph_b = int'($urandom_range(1, 3));
            else if ($urandom_range(0, 99) < 30) gph_b = gph_b % 3 + 1;
            if (gph_a != 3 && $urandom_range(0, 9) < 8) gph_b = 3;
            pa = ($urandom_range(0, 99) < 4) ? 3'($urandom) : pat(gph_a);
            pb = ($urandom_range(0, 99) < 4) ? 3'($urandom) : pat(gph_b);
            drive(pa, pb, 1'($urandom), 1'($urandom), ($urandom_range(0, 24) == 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
